// File: rtl/touch_dir_event_ctrl_pkg.sv
// Shared encodings and helpers for the touch-panel direction event controller.
package touch_dir_event_ctrl_pkg;

  typedef logic [1:0] dir_t;

  // Direction encoding seen by the consumer on move_dir
  localparam dir_t DIR_RIGHT = 2'd0;
  localparam dir_t DIR_UP    = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_DOWN  = 2'd3;

  // Debounce / repeat state machine encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_HOLD     = 3'd2;
  localparam logic [2:0] ST_REPEAT   = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  // True when exactly one of the four qualified button bits is set
  function automatic logic is_single(input logic [3:0] s);
    logic r;
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Encode a single-hot sample {down,left,up,right} as a direction code
  function automatic dir_t onehot_to_dir(input logic [3:0] s);
    dir_t d;
    case (s)
      4'b0001: d = DIR_RIGHT;
      4'b0010: d = DIR_UP;
      4'b0100: d = DIR_LEFT;
      4'b1000: d = DIR_DOWN;
      default: d = DIR_RIGHT;
    endcase
    return d;
  endfunction

  // Direction code back to its one-hot button position
  function automatic logic [3:0] dir_to_onehot(input dir_t d);
    logic [3:0] s;
    case (d)
      DIR_RIGHT: s = 4'b0001;
      DIR_UP:    s = 4'b0010;
      DIR_LEFT:  s = 4'b0100;
      DIR_DOWN:  s = 4'b1000;
      default:   s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/touch_dir_event_ctrl_if.sv
// Button inputs, move event handshake and LED status of the controller.
interface touch_dir_event_ctrl_if;
  logic       pen_down;
  logic       right_button;
  logic       up_button;
  logic       left_button;
  logic       down_button;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [7:0] LEDG;
  logic [7:0] LEDR;

  // Panel decoder and event consumer side
  modport master (
    output pen_down, right_button, up_button, left_button, down_button, move_ready,
    input  move_valid, move_dir, LEDG, LEDR
  );

  // Controller side
  modport slave (
    input  pen_down, right_button, up_button, left_button, down_button, move_ready,
    output move_valid, move_dir, LEDG, LEDR
  );
endinterface

// File: rtl/touch_dir_event_ctrl_buffer.sv
// One-entry valid/ready event buffer with overflow flag and accepted-event counter.
module dir_event_buffer
  import touch_dir_event_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       emit,
  input  dir_t       emit_dir,
  input  logic       move_ready,
  output logic       move_valid,
  output dir_t       move_dir,
  output logic [7:0] ledr
);

  logic       valid_q, valid_d;
  dir_t       dir_q, dir_d;
  logic [6:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       pop_s;

  assign pop_s = valid_q & move_ready;

  // Load, drop or pop the single entry; count pops and remember any drop
  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (emit) begin
      if (!valid_q || pop_s) begin
        valid_d = 1'b1;
        dir_d   = emit_dir;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      if (pop_s) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
    if (pop_s) begin
      cnt_d = cnt_q + 7'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      dir_q   <= DIR_RIGHT;
      cnt_q   <= 7'd0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign move_valid = valid_q;
  assign move_dir   = dir_q;
  assign ledr       = {ovf_q, cnt_q};

endmodule

// File: rtl/touch_dir_event_ctrl.sv
// Debounces touch-panel direction buttons and emits single and auto-repeat move events.
module touch_dir_event_ctrl
  import touch_dir_event_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 3,
  parameter int CNT_W           = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  touch_dir_event_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_TGT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DLY_TGT  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PER_TGT  = CNT_W'(REPEAT_PERIOD);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  dir_t             cand_q, cand_d;
  logic [3:0]       ledg_q, ledg_d;

  logic [3:0]       sample_s;
  logic             single_s;
  logic             none_s;
  logic             match_s;
  dir_t             sample_dir_s;
  logic [CNT_W-1:0] timer_inc_s;
  logic             emit_s;
  dir_t             emit_dir_s;

  // Pen contact gates the decoder levels; multi-button samples are neither single nor none
  assign sample_s     = {bus.down_button, bus.left_button, bus.up_button, bus.right_button}
                        & {4{bus.pen_down}};
  assign single_s     = is_single(sample_s);
  assign none_s       = (sample_s == 4'b0000);
  assign sample_dir_s = onehot_to_dir(sample_s);
  assign match_s      = (sample_s == dir_to_onehot(cand_q));
  assign timer_inc_s  = (timer_q == CNT_MAX) ? timer_q : (timer_q + CNT_ONE);

  // Next-state, timer and event generation for the debounce/repeat machine
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cand_d     = cand_q;
    emit_s     = 1'b0;
    emit_dir_s = cand_q;
    case (state_q)
      ST_IDLE: begin
        if (single_s) begin
          cand_d = sample_dir_s;
          if (DEB_TGT <= CNT_ONE) begin
            emit_s     = 1'b1;
            emit_dir_s = sample_dir_s;
            timer_d    = CNT_ZERO;
            state_d    = ST_HOLD;
          end else begin
            timer_d = CNT_ONE;
            state_d = ST_DEBOUNCE;
          end
        end else begin
          timer_d = CNT_ZERO;
        end
      end
      ST_DEBOUNCE: begin
        if (match_s) begin
          if (timer_inc_s >= DEB_TGT) begin
            emit_s  = 1'b1;
            timer_d = CNT_ZERO;
            state_d = ST_HOLD;
          end else begin
            timer_d = timer_inc_s;
          end
        end else begin
          timer_d = CNT_ZERO;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (match_s) begin
          if (timer_inc_s >= DLY_TGT) begin
            emit_s  = 1'b1;
            timer_d = CNT_ZERO;
            state_d = ST_REPEAT;
          end else begin
            timer_d = timer_inc_s;
          end
        end else begin
          timer_d = CNT_ZERO;
          state_d = ST_RELEASE;
        end
      end
      ST_REPEAT: begin
        if (match_s) begin
          if (timer_inc_s >= PER_TGT) begin
            emit_s  = 1'b1;
            timer_d = CNT_ZERO;
          end else begin
            timer_d = timer_inc_s;
          end
        end else begin
          timer_d = CNT_ZERO;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Any touch restarts the release count so a new direction waits for a clean lift
        if (none_s) begin
          if (timer_inc_s >= DEB_TGT) begin
            timer_d = CNT_ZERO;
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_inc_s;
          end
        end else begin
          timer_d = CNT_ZERO;
        end
      end
      default: begin
        timer_d = CNT_ZERO;
        cand_d  = DIR_RIGHT;
        state_d = ST_IDLE;
      end
    endcase
    ledg_d = ((state_d == ST_HOLD) || (state_d == ST_REPEAT)) ? dir_to_onehot(cand_d) : 4'b0000;
  end

  // State machine and LED registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= CNT_ZERO;
      cand_q  <= DIR_RIGHT;
      ledg_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cand_q  <= cand_d;
      ledg_q  <= ledg_d;
    end
  end

  logic       buf_valid_s;
  dir_t       buf_dir_s;
  logic [7:0] buf_ledr_s;

  dir_event_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .emit       (emit_s),
    .emit_dir   (emit_dir_s),
    .move_ready (bus.move_ready),
    .move_valid (buf_valid_s),
    .move_dir   (buf_dir_s),
    .ledr       (buf_ledr_s)
  );

  assign bus.move_valid = buf_valid_s;
  assign bus.move_dir   = buf_dir_s;
  assign bus.LEDR       = buf_ledr_s;
  assign bus.LEDG       = {4'b0000, ledg_q};

endmodule
